// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM states, adder/subtractor
// op encodings and the divide-by-zero quotient fill.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Quotient reported for a zero divisor is this bit replicated to full width.
  localparam logic DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of the sequential divider; master launches divisions,
// slave (the divider) returns status and results.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/adder_subtractor.sv
// Generic W-bit adder/subtractor: result = a + b (op=OP_ADD) or a - b (op=OP_SUB),
// with two's complement overflow flag.
module adder_subtractor
  import div_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] result,
  output logic         overflow
);
  logic [W-1:0] b_eff;
  logic [W-1:0] carry_in;

  always_comb begin
    b_eff    = (op == OP_SUB) ? ~b : b;
    carry_in = {{(W-1){1'b0}}, op};
    result   = a + b_eff + carry_in;
    overflow = (a[W-1] == b_eff[W-1]) && (result[W-1] != a[W-1]);
  end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             accept;
  logic             finish;
  logic             zero_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dq_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             sub_ovf_unused;

  assign zero_div = (bus.divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = zero_div ? DONE : CALC;
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Dividend register doubles as the quotient shift register: its MSB feeds the
  // partial remainder while each new quotient bit enters at the LSB.
  always_comb begin
    partial = {rem, dq[WIDTH-1]};
    take    = ~diff[WIDTH];
    rem_nxt = take ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    dq_nxt  = {dq[WIDTH-2:0], take};
  end

  adder_subtractor #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a        (partial),
    .b        ({1'b0, dvs}),
    .op       (OP_SUB),
    .result   (diff),
    .overflow (sub_ovf_unused)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg;
  logic r_neg;

  always_comb begin
    a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    q_fix = q_neg ? -dq_nxt  : dq_nxt;
    r_fix = r_neg ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept && !zero_div) begin
      q_neg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg <= bus.dividend[WIDTH-1];
    end
  end
`else
  always_comb begin
    a_mag = bus.dividend;
    b_mag = bus.divisor;
    q_fix = dq_nxt;
    r_fix = rem_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      rem         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      dbz_q <= 1'b0;
      if (zero_div) begin
        quotient_q  <= {WIDTH{DIV0_Q_BIT}};
        remainder_q <= bus.dividend;
        dbz_q       <= 1'b1;
      end else begin
        dq  <= a_mag;
        dvs <= b_mag;
        rem <= '0;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      dq  <= dq_nxt;
      rem <= rem_nxt;
      if (finish) begin
        quotient_q  <= q_fix;
        remainder_q <= r_fix;
      end
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus random operands
// against an arithmetic reference model (honours SEQ_DIVIDER_SIGNED_EN).
module tb_seq_divider;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // Drive a start for one edge; returns in the first cycle after acceptance.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
  endtask

  // elapsed: index of the current cycle counted from the accepting edge.
  task automatic wait_done(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int unsigned elapsed);
    int unsigned n;
    int unsigned busy_err;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic z;
    n        = elapsed;
    busy_err = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== ((b == '0) ? 1'b0 : 1'b1)) busy_err++;
      tick();
      n++;
    end
    model(a, b, q, r, z);
    check({tag, "/latency"}, n, (b == '0) ? 1 : W + 1);
    check({tag, "/busy"}, busy_err, 0);
    check({tag, "/busy_in_done"}, bus.busy, 1'b0);
    check({tag, "/quotient"}, bus.quotient, q);
    check({tag, "/remainder"}, bus.remainder, r);
    check({tag, "/div_by_zero"}, bus.div_by_zero, z);
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    launch(a, b);
    wait_done(tag, a, b, 1);
  endtask

  initial begin
    int unsigned dones;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] hq;
    logic [W-1:0] hr;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    check("reset/busy", bus.busy, 1'b0);
    check("reset/done", bus.done, 1'b0);
    check("reset/quotient", bus.quotient, 8'h00);
    check("reset/remainder", bus.remainder, 8'h00);
    check("reset/dbz", bus.div_by_zero, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run("d100_7", 8'd100, 8'd7);
    tick();
    run("d255_1", 8'd255, 8'd1);
    tick();
    run("d5_9", 8'd5, 8'd9);
    tick();
    run("d42_0", 8'd42, 8'd0);
    tick();
    run("d0_5", 8'd0, 8'd5);
    tick();
    run("d255_255", 8'd255, 8'd255);
    tick();
    run("d42_0b", 8'd42, 8'd0);

    // Start while busy must be ignored; a start held in DONE is accepted.
    launch(8'd200, 8'd10);
    check("accept/dbz_cleared", bus.div_by_zero, 1'b0);
    tick();
    tick();
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd3;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    wait_done("busy_start", 8'd200, 8'd10, 4);
    run("b2b_50_3", 8'd50, 8'd3);
    hq    = bus.quotient;
    hr    = bus.remainder;
    dones = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("no_extra_done", dones, 0);
    model(8'd50, 8'd3, hq, hr, ra[0]);
    check("hold/quotient", bus.quotient, hq);
    check("hold/remainder", bus.remainder, hr);

    // Reset during CALC cycle 4.
    launch(8'd77, 8'd5);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midreset/busy", bus.busy, 1'b0);
    check("midreset/done", bus.done, 1'b0);
    check("midreset/quotient", bus.quotient, 8'h00);
    check("midreset/remainder", bus.remainder, 8'h00);
    check("midreset/dbz", bus.div_by_zero, 1'b0);
    dones = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    check("midreset/no_done", dones, 0);
    run("d9_3", 8'd9, 8'd3);

`ifdef SEQ_DIVIDER_SIGNED_EN
    tick();
    run("s_m7_2", 8'hF9, 8'd2);
    check("s_m7_2/q_lit", bus.quotient, 8'hFD);
    check("s_m7_2/r_lit", bus.remainder, 8'hFF);
    tick();
    run("s_7_m2", 8'd7, 8'hFE);
    check("s_7_m2/q_lit", bus.quotient, 8'hFD);
    check("s_7_m2/r_lit", bus.remainder, 8'h01);
    tick();
    run("s_m128_m1", 8'h80, 8'hFF);
    check("s_m128_m1/q_lit", bus.quotient, 8'h80);
    check("s_m128_m1/r_lit", bus.remainder, 8'h00);
    check("s_m128_m1/dbz", bus.div_by_zero, 1'b0);
`else
    check("d9_3/q_lit", bus.quotient, 8'd3);
    check("d9_3/r_lit", bus.remainder, 8'd0);
`endif

    for (int unsigned i = 0; i < 30; i++) begin
      ra = W'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)      rb = '0;
      else if ($urandom_range(0, 2) == 0) rb = W'($urandom_range(1, 15));
      else                                rb = W'($urandom_range(1, 255));
      // Zero idle cycles here exercises back-to-back acceptance in DONE.
      for (int unsigned j = $urandom_range(0, 2); j > 0; j--) tick();
      run($sformatf("rnd%0d_%0d_%0d", i, ra, rb), ra, rb);
    end

    tick();
    check("final/done_low", bus.done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
